circ01_checker: RTL

Self-checking monitor that sits directly downstream of the `circ01` two-flop inverting pipeline. It observes the stimulus bit driven into `circ01` (`a`) and the pipeline output (`y`). It verifies on every clock that `y` equals the inverse of `a` sampled LAT cycles earlier, and reports per-cycle mismatch pulses, a sticky fail flag, saturating error and check counters, and the check index of the first failure. It is used as the on-chip/bench scoreboard for the STA exercise circuits.

---
 rtl/circ01_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/circ01_checker.sv
// Scoreboard for the circ01 inverting pipeline: checks y == ~a from LAT edges earlier.
// Registered outputs; mismatch pulse, sticky fail, saturating counters, first-failure index.
module circ01_checker #(
  parameter int LAT   = 2,
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rb,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             y,
  output logic [1:0]       state,
  output logic             err,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CYC_W-1:0] chk_cnt,
  output logic [CYC_W-1:0] first_err_cyc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_CHECK = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);
  localparam logic [CYC_W-1:0] CHK_ONE = CYC_W'(1);

  state_t           r_state;
  logic [LAT-1:0]   r_hist;
  logic [LAT-1:0]   r_vld;
  logic [LAT-1:0]   w_vld_nxt;
  logic             w_cmp;
  logic             w_mis;
  logic             r_err;
  logic             r_fail;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CYC_W-1:0] r_chk_cnt;
  logic [CYC_W-1:0] r_first;

  // Valid bits drop to zero whenever en is low, so re-enable always refills.
  always_comb begin
    w_vld_nxt = '0;
    if (en) begin
      for (int i = LAT - 1; i > 0; i--) w_vld_nxt[i] = r_vld[i-1];
      w_vld_nxt[0] = 1'b1;
    end
  end

  assign w_cmp = en & r_vld[LAT-1];
  assign w_mis = w_cmp & (y != ~r_hist[LAT-1]);

  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      r_hist <= '0;
      r_vld  <= '0;
    end else begin
      if (en) begin
        for (int i = LAT - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
        r_hist[0] <= a;
      end
      r_vld <= w_vld_nxt;
    end
  end

  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_FILL, S_CHECK: begin
          if (!en)                       r_state <= S_IDLE;
          else if (w_vld_nxt[LAT-1])     r_state <= S_CHECK;
          else                           r_state <= S_FILL;
        end
        default:                         r_state <= S_IDLE;
      endcase
    end
  end

  // clr wins over a comparison at the same edge; that comparison is dropped.
  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      r_err     <= 1'b0;
      r_fail    <= 1'b0;
      r_err_cnt <= '0;
      r_chk_cnt <= '0;
      r_first   <= '0;
    end else if (clr) begin
      r_err     <= 1'b0;
      r_fail    <= 1'b0;
      r_err_cnt <= '0;
      r_chk_cnt <= '0;
      r_first   <= '0;
    end else if (w_cmp) begin
      r_err <= w_mis;
      if (r_chk_cnt != '1) r_chk_cnt <= r_chk_cnt + CHK_ONE;
      if (w_mis) begin
        r_fail <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_ONE;
        if (!r_fail) r_first <= r_chk_cnt;
      end
    end else begin
      r_err <= 1'b0;
    end
  end

  assign state         = r_state;
  assign err           = r_err;
  assign fail          = r_fail;
  assign err_cnt       = r_err_cnt;
  assign chk_cnt       = r_chk_cnt;
  assign first_err_cyc = r_first;

endmodule
